// File: rtl/sprite_row_renderer.sv
// sprite_row_renderer: per-scanline row fetch from the sprite asset ROM and
// serialisation of that row into per-pixel opaque / in-box flags.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for line_start
// S_ADDR    | rom_* just registered from the line_start samples, ROM settling
// S_CAPTURE | rom_data is latched into the pending row
module sprite_row_renderer #(
  parameter int SCALE_LOG2 = 1,
  parameter int V_TOTAL    = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       line_start,
  input  logic       sprite_en,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic [3:0] sprite_charc,
  input  logic [1:0] sprite_dir,
  output logic [3:0] rom_charc,
  output logic [1:0] rom_dir,
  output logic [2:0] rom_index,
  input  logic [7:0] rom_data,
  output logic       pixel_on,
  output logic       in_box
);

  localparam int                REP_W     = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'((1 << SCALE_LOG2) - 1);
  localparam logic signed [10:0] ROWS     = 11'sd8 <<< SCALE_LOG2;
  localparam logic [9:0]        LAST_LINE = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CAPTURE} state_t;

  state_t r_state, w_state_nxt;

  logic [9:0]         w_next_line;
  logic signed [10:0] w_dy;
  logic               w_in_range;
  logic [2:0]         w_row_idx;
  logic               w_sample, w_capture, w_swap, w_start;

  logic [9:0]       r_samp_x;
  logic             r_samp_in_range;
  logic [7:0]       r_pend_row, r_act_row;
  logic [9:0]       r_pend_x, r_act_x;
  logic             r_pend_valid, r_act_valid;
  logic [7:0]       r_shreg;
  logic [REP_W-1:0] r_rep_cnt;
  logic [2:0]       r_col_cnt;
  logic             r_drawing;

  // Row arithmetic for the line after the current one; no wrap of the sprite box.
  assign w_next_line = (vpos == LAST_LINE) ? 10'd0 : vpos + 10'd1;
  assign w_dy        = $signed({1'b0, w_next_line}) - $signed({1'b0, sprite_y});
  assign w_in_range  = sprite_en && (w_dy >= 11'sd0) && (w_dy < ROWS);
  assign w_row_idx   = 3'($unsigned(w_dy) >> SCALE_LOG2);

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch FSM next state; line_start from any state restarts the fetch.
  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_IDLE;
        S_ADDR:    w_state_nxt = S_CAPTURE;
        S_CAPTURE: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Fetch FSM control outputs; a restart in CAPTURE discards the old fetch.
  always_comb begin
    w_sample  = line_start;
    w_capture = (r_state == S_CAPTURE) && !line_start;
  end

  // Attribute samples and ROM address, held until the next line_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_charc       <= '0;
      rom_dir         <= '0;
      rom_index       <= '0;
      r_samp_x        <= '0;
      r_samp_in_range <= 1'b0;
    end else if (w_sample) begin
      rom_charc       <= sprite_charc;
      rom_dir         <= sprite_dir;
      rom_index       <= w_row_idx;
      r_samp_x        <= sprite_x;
      r_samp_in_range <= w_in_range;
    end
  end

  assign w_swap = (hpos == 10'd0);

  // Pending/active row double buffer; a same-cycle capture overrides the swap clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_row   <= 8'hFF;
      r_pend_x     <= '0;
      r_pend_valid <= 1'b0;
      r_act_row    <= 8'hFF;
      r_act_x      <= '0;
      r_act_valid  <= 1'b0;
    end else begin
      if (w_swap) begin
        r_act_row   <= r_pend_row;
        r_act_x     <= r_pend_x;
        r_act_valid <= r_pend_valid;
      end
      if (w_capture) begin
        r_pend_row   <= rom_data;
        r_pend_x     <= r_samp_x;
        r_pend_valid <= r_samp_in_range;
      end else if (w_swap) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // At hpos 0 the active row is being replaced, so a sprite at x=0 starts from pend.
  assign w_start = w_swap ? (r_pend_valid && (r_pend_x == 10'd0))
                          : (r_act_valid && (hpos == r_act_x));

  // Row serialiser: each ROM bit is held for 2^SCALE_LOG2 pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg   <= 8'hFF;
      r_rep_cnt <= '0;
      r_col_cnt <= '0;
      r_drawing <= 1'b0;
    end else if (w_start) begin
      r_shreg   <= w_swap ? r_pend_row : r_act_row;
      r_rep_cnt <= '0;
      r_col_cnt <= '0;
      r_drawing <= 1'b1;
    end else if (w_swap) begin
      r_drawing <= 1'b0;
    end else if (r_drawing) begin
      if (r_rep_cnt == REP_MAX) begin
        r_rep_cnt <= '0;
        r_shreg   <= {r_shreg[6:0], 1'b1};
        r_col_cnt <= r_col_cnt + 3'd1;
        if (r_col_cnt == 3'd7) r_drawing <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign in_box   = r_drawing;
  assign pixel_on = r_drawing & ~r_shreg[7];

endmodule

// File: tb/tb_sprite_row_renderer.sv
// Directed bench for sprite_row_renderer with a small behavioural asset ROM.
module tb_sprite_row_renderer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       line_start, sprite_en;
  logic [9:0] sprite_x, sprite_y;
  logic [3:0] sprite_charc;
  logic [1:0] sprite_dir;
  logic [3:0] rom_charc;
  logic [1:0] rom_dir;
  logic [2:0] rom_index;
  logic [7:0] rom_data;
  logic       pixel_on, in_box;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sprite_row_renderer #(.SCALE_LOG2(1), .V_TOTAL(525)) dut (
    .clk(clk), .reset(rst_n), .hpos(hpos), .vpos(vpos), .line_start(line_start),
    .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_charc(sprite_charc), .sprite_dir(sprite_dir),
    .rom_charc(rom_charc), .rom_dir(rom_dir), .rom_index(rom_index),
    .rom_data(rom_data), .pixel_on(pixel_on), .in_box(in_box)
  );

  // Asset ROM: charc 0 = heart row, 1 = fully opaque, 2 = right half opaque.
  always_comb begin
    case (rom_charc)
      4'd0:    rom_data = 8'b1001_1001;
      4'd1:    rom_data = 8'b0000_0000;
      4'd2:    rom_data = 8'b1111_0000;
      default: rom_data = 8'hFF;
    endcase
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic ib_line [0:799];
  logic po_line [0:799];
  int          g_ls2_h = -1;
  logic [3:0]  g_ls2_charc = 4'd0;
  int          g_xchg_h = -1;
  logic [9:0]  g_xchg_x = 10'd0;

  // One scanline: 800 pixels, line_start at the first blank pixel (640).
  task automatic run_line(input int v, input int h_last);
    vpos = 10'(v);
    for (int h = 0; h < 800; h++) begin
      ib_line[h] = 1'b0;
      po_line[h] = 1'b0;
    end
    for (int h = 0; h <= h_last; h++) begin
      hpos       = 10'(h);
      line_start = (h == 640) || (h == g_ls2_h);
      if (h == g_ls2_h)  sprite_charc = g_ls2_charc;
      if (h == g_xchg_h) sprite_x     = g_xchg_x;
      @(negedge clk);
      ib_line[h] = in_box;
      po_line[h] = pixel_on;
      @(posedge clk);
      #1;
    end
    line_start = 1'b0;
    g_ls2_h    = -1;
    g_xchg_h   = -1;
  endtask

  int          ln_first, ln_cnt;
  logic [15:0] ln_mask;

  task automatic summarize();
    ln_first = -1;
    ln_cnt   = 0;
    ln_mask  = '0;
    for (int h = 0; h < 800; h++) begin
      if (ib_line[h]) begin
        if (ln_first < 0) ln_first = h;
        ln_cnt++;
      end
    end
    if (ln_first >= 0)
      for (int k = 0; k < 16; k++)
        if (ln_first + k < 800) ln_mask[15-k] = po_line[ln_first + k];
  endtask

  task automatic check_draw(input string tag, input int first, input int cnt,
                            input logic [15:0] mask);
    summarize();
    check_val({tag, "_first"}, ln_first, first);
    check_val({tag, "_count"}, ln_cnt, cnt);
    check_val({tag, "_mask"}, int'(ln_mask), int'(mask));
  endtask

  task automatic check_none(input string tag);
    summarize();
    check_val({tag, "_count"}, ln_cnt, 0);
  endtask

  localparam logic [15:0] M_HEART = 16'h3C3C;
  localparam logic [15:0] M_RIGHT = 16'h00FF;

  int early_cnt;

  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0; line_start = 1'b0;
    sprite_en = 1'b1; sprite_x = 10'd200; sprite_y = 10'd100;
    sprite_charc = 4'd0; sprite_dir = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pixel_on", int'(pixel_on), 0);
    check_val("rst_in_box", int'(in_box), 0);
    check_val("rst_rom_index", int'(rom_index), 0);
    check_val("rst_rom_charc", int'(rom_charc), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vertical band and heart row.
    run_line(99, 799);
    check_none("l99_nodraw");
    check_val("l99_idx", int'(rom_index), 0);
    run_line(100, 799);
    check_draw("heart_l100", 201, 16, M_HEART);
    check_val("l100_idx", int'(rom_index), 0);
    run_line(101, 799);
    check_val("l101_idx", int'(rom_index), 1);
    run_line(114, 799);
    check_val("l114_idx", int'(rom_index), 7);
    run_line(115, 799);
    check_draw("l115_draw", 201, 16, M_HEART);
    run_line(116, 799);
    check_none("l116_nodraw");

    // Frame wrap.
    sprite_y = 10'd0;
    run_line(524, 799);
    check_val("wrap_idx", int'(rom_index), 0);
    run_line(0, 799);
    check_draw("wrap_l0", 201, 16, M_HEART);
    sprite_y = 10'd520;
    run_line(524, 799);
    run_line(0, 799);
    check_none("wrap_neg_dy");

    // Restart: second line_start two pixels later with a new asset.
    sprite_y = 10'd100; sprite_charc = 4'd1;
    g_ls2_h = 642; g_ls2_charc = 4'd2;
    run_line(99, 799);
    check_val("restart_charc", int'(rom_charc), 2);
    run_line(100, 799);
    check_draw("restart_row", 201, 16, M_RIGHT);

    // Mid-line x change only takes effect on the next line.
    sprite_charc = 4'd0;
    g_xchg_h = 150; g_xchg_x = 10'd300;
    run_line(101, 799);
    check_draw("xchg_cur", 201, 16, M_RIGHT);
    sprite_x = 10'd630;
    run_line(102, 799);
    check_draw("xchg_next", 301, 16, M_HEART);

    // Right edge: drawing continues into blank, then is cut by hpos 0.
    sprite_x = 10'd795;
    run_line(103, 799);
    check_draw("edge_blank", 631, 16, M_HEART);
    run_line(104, 799);
    summarize();
    check_val("abort_first", ln_first, 796);
    check_val("abort_count", ln_cnt, 4);
    sprite_x = 10'd200;
    run_line(105, 799);
    check_val("abort_h0_carry", int'(ib_line[0]), 1);
    early_cnt = 0;
    for (int h = 1; h <= 20; h++) if (ib_line[h]) early_cnt++;
    check_val("abort_after_h0", early_cnt, 0);

    // Asynchronous reset in the middle of a draw.
    run_line(106, 205);
    check_val("pre_rst_in_box", int'(in_box), 1);
    check_val("pre_rst_pixel_on", int'(pixel_on), 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_in_box", int'(in_box), 0);
    check_val("mid_rst_pixel_on", int'(pixel_on), 0);
    check_val("mid_rst_rom_index", int'(rom_index), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_line(107, 799);
    check_none("post_rst_nodraw");
    run_line(108, 799);
    check_draw("post_rst_draw", 201, 16, M_HEART);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
